muldiv: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It executes the R-type mult, multu, div, divu, mthi and mtlo instructions as a multicycle sequencer beside the single-cycle ALU. It exposes busy so the pipeline/control logic can stall mfhi, mflo and any new muldiv instruction. The arithmetic is one shift-add or shift-subtract step per cycle over a 64-bit working register.

---
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv.sv | 151 +++++++++++++++
 tb/tb_muldiv.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - issue/result bundle between the pipeline and the muldiv sequencer
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, funct, srca, srcb, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, funct, srca, srcb, cancel,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative shift-add multiply / restoring divide with HI/LO registers
module muldiv #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_opa;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_is_div;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_is_mul;
  logic               w_is_div;
  logic               w_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic               w_div0;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_is_mul = (bus.funct == F_MULT) || (bus.funct == F_MULTU);
  assign w_is_div = (bus.funct == F_DIV)  || (bus.funct == F_DIVU);
  assign w_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
  assign w_neg_a  = w_signed & bus.srca[WIDTH-1];
  assign w_neg_b  = w_signed & bus.srcb[WIDTH-1];
  assign w_div0   = (bus.srcb == '0);
  assign w_mag_a  = w_neg_a ? -bus.srca : bus.srca;
  assign w_mag_b  = w_neg_b ? -bus.srcb : bus.srcb;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign w_add    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){r_acc[0]}} & {1'b0, r_opa});
  // Divide: acc = {remainder, dividend/quotient bits}, shifted left each step.
  assign w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff   = w_rem_sh - {1'b0, r_opa};

  assign w_prod   = r_neg_q ? -r_acc : r_acc;
  assign w_quo    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_opa    <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.cancel) begin
            if (bus.funct == F_MTHI) begin
              r_hi <= bus.srca;
            end else if (bus.funct == F_MTLO) begin
              r_lo <= bus.srca;
            end else if (w_is_mul) begin
              r_opa    <= w_mag_a;
              r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
              r_neg_q  <= w_neg_a ^ w_neg_b;
              r_neg_r  <= 1'b0;
              r_is_div <= 1'b0;
              r_count  <= '0;
              r_state  <= S_MUL;
            end else if (w_is_div) begin
              // Divide by zero keeps the raw dividend so it lands in HI untouched.
              r_opa    <= w_mag_b;
              r_acc    <= {{WIDTH{1'b0}}, (w_div0 ? bus.srca : w_mag_a)};
              r_neg_q  <= ~w_div0 & (w_neg_a ^ w_neg_b);
              r_neg_r  <= ~w_div0 & w_neg_a;
              r_is_div <= 1'b1;
              r_count  <= '0;
              r_state  <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (bus.cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_acc   <= {w_add, r_acc[WIDTH-1:1]};
            r_count <= r_count + CW'(1);
            if (r_count == LAST) r_state <= S_FIX;
          end
        end
        S_DIV: begin
          if (bus.cancel) begin
            r_state <= S_IDLE;
          end else begin
            if (w_diff[WIDTH]) r_acc <= {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            else               r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            r_count <= r_count + CW'(1);
            if (r_count == LAST) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!bus.cancel) begin
            if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
            r_done <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - randomized self-checking bench for muldiv against an arithmetic reference
module tb_muldiv;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv #(.WIDTH(32)) u_dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [5:0]  t_f  [6] = '{F_MULTU, F_MULT, F_DIV, F_DIVU, F_DIVU, F_DIV};
  logic [31:0] t_a  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h1234, 32'h80000000};
  logic [31:0] t_b  [6] = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd7, 32'd0, 32'hFFFFFFFF};
  logic [31:0] t_hi [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'h1234, 32'h0};
  logic [31:0] t_lo [6] = '{32'h00000001, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF, 32'h80000000};
  logic [31:0] corners [4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h1};
  logic [5:0]  ops [4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};

  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h = '0;
    l = '0;
    case (f)
      F_MULT:  begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      F_MULTU: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
      F_DIV: begin
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      F_DIVU: begin
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else begin h = a % b; l = a / b; end
      end
      default: ;
    endcase
  endfunction

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct = f;
    bus.srca  = a;
    bus.srcb  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n_edges, output int n_busy);
    n_busy  = bus.busy ? 1 : 0;
    n_edges = 0;
    while (n_edges < 100) begin
      @(posedge clk);
      #1;
      n_edges++;
      if (bus.done) break;
      if (bus.busy) n_busy++;
    end
  endtask

  task automatic test_reset;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    n_cmp++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    @(negedge clk);
    reset = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
  endtask

  task automatic test_directed;
    int ne, nb;
    for (int i = 0; i < 6; i++) begin
      issue(t_f[i], t_a[i], t_b[i]);
      wait_done(ne, nb);
      if (i == 0) begin
        n_cmp++; if (ne !== 33) begin n_fail++; $display("FAIL latency: got %0d want 33", ne); end
        n_cmp++; if (nb !== 33) begin n_fail++; $display("FAIL busy_cycles: got %0d want 33", nb); end
      end
      n_cmp++; if (bus.hi !== t_hi[i]) begin n_fail++; $display("FAIL dir_hi[%0d]: got %h want %h", i, bus.hi, t_hi[i]); end
      n_cmp++; if (bus.lo !== t_lo[i]) begin n_fail++; $display("FAIL dir_lo[%0d]: got %h want %h", i, bus.lo, t_lo[i]); end
      exp_hi = t_hi[i];
      exp_lo = t_lo[i];
    end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_mthi_mtlo;
    issue(F_MTHI, 32'hAAAA5555, 32'h0);
    n_cmp++; if (bus.hi !== 32'hAAAA5555) begin n_fail++; $display("FAIL mthi: got %h want aaaa5555", bus.hi); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
    issue(F_MTLO, 32'h0F0F0F0F, 32'h0);
    n_cmp++; if (bus.lo !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL mtlo: got %h want 0f0f0f0f", bus.lo); end
    n_cmp++; if (bus.hi !== 32'hAAAA5555) begin n_fail++; $display("FAIL mtlo_hi: got %h want aaaa5555", bus.hi); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %b want 0", bus.busy); end
    exp_hi = 32'hAAAA5555;
    exp_lo = 32'h0F0F0F0F;
    issue(6'b100000, $urandom, $urandom);
    @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bad_funct_busy: got %b want 0", bus.busy); end
    n_cmp++; if ({bus.hi, bus.lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL bad_funct_hilo: got %h want %h", {bus.hi, bus.lo}, {exp_hi, exp_lo}); end
    bus.cancel = 1'b1;
    issue(F_MTHI, 32'h12345678, 32'h0);
    bus.cancel = 1'b0;
    n_cmp++; if (bus.hi !== exp_hi) begin n_fail++; $display("FAIL cancel_mthi: got %h want %h", bus.hi, exp_hi); end
  endtask

  task automatic test_start_while_busy;
    int ne, nb;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    model(F_MULT, a, b, exp_hi, exp_lo);
    issue(F_MULT, a, b);
    repeat (9) @(posedge clk);
    issue(F_DIV, $urandom, $urandom);
    wait_done(ne, nb);
    n_cmp++; if (ne + 10 !== 33) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 33", ne + 10); end
    n_cmp++; if ({bus.hi, bus.lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL busy_start_result: got %h want %h", {bus.hi, bus.lo}, {exp_hi, exp_lo}); end
  endtask

  task automatic test_cancel;
    int seen;
    issue(F_MULT, $urandom, $urandom);
    repeat (19) @(posedge clk);
    @(negedge clk);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b want 0", bus.busy); end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL cancel_done: got %0d pulses want 0", seen); end
    n_cmp++; if ({bus.hi, bus.lo} !== {exp_hi, exp_lo}) begin n_fail++; $display("FAIL cancel_hilo: got %h want %h", {bus.hi, bus.lo}, {exp_hi, exp_lo}); end
  endtask

  task automatic test_reset_mid;
    int ne, nb;
    issue(F_DIV, $urandom, $urandom_range(1, 1000));
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    n_cmp++; if ({bus.hi, bus.lo} !== 64'h0) begin n_fail++; $display("FAIL rst_mid_hilo: got %h want 0", {bus.hi, bus.lo}); end
    @(negedge clk);
    reset = 1'b1;
    issue(F_MULTU, 32'd5, 32'd6);
    wait_done(ne, nb);
    n_cmp++; if (bus.lo !== 32'd30) begin n_fail++; $display("FAIL post_rst_lo: got %h want 1e", bus.lo); end
    n_cmp++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL post_rst_hi: got %h want 0", bus.hi); end
    exp_hi = 32'd0;
    exp_lo = 32'd30;
  endtask

  task automatic test_back_to_back;
    int ne, nb;
    logic [5:0]  f;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      f = ops[$urandom_range(0, 3)];
      a = ($urandom_range(0, 5) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 5) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 15);
      model(f, a, b, exp_hi, exp_lo);
      issue(f, a, b);
      n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept[%0d]: busy %b want 1", i, bus.busy); end
      wait_done(ne, nb);
      n_cmp++; if (ne !== 33) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d want 33", i, ne); end
      n_cmp++; if (bus.hi !== exp_hi) begin n_fail++; $display("FAIL rnd_hi[%0d] f=%b a=%h b=%h: got %h want %h", i, f, a, b, bus.hi, exp_hi); end
      n_cmp++; if (bus.lo !== exp_lo) begin n_fail++; $display("FAIL rnd_lo[%0d] f=%b a=%h b=%h: got %h want %h", i, f, a, b, bus.lo, exp_lo); end
    end
  endtask

  initial begin
    clk        = 1'b0;
    reset      = 1'b0;
    n_cmp      = 0;
    n_fail     = 0;
    bus.start  = 1'b0;
    bus.funct  = '0;
    bus.srca   = '0;
    bus.srcb   = '0;
    bus.cancel = 1'b0;
    #12;
    test_reset;
    test_directed;
    test_mthi_mtlo;
    test_start_while_busy;
    test_cancel;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
